// File: rtl/ecc_chk_pipe.sv
// Two-stage Hamming SEC checker for the EEPROM read path: stage 1 computes the syndrome,
// stage 2 corrects single-bit errors, flags uncorrectable words and keeps error statistics.
module ecc_chk_pipe #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ecc_enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic [5:0]        in_ecc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic [5:0]        out_ecc,
  output logic [5:0]        out_syn,
  output logic              out_sec,
  output logic              out_ued,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ued_cnt,
  output logic              fail_vld,
  output logic [ADDR_W-1:0] fail_addr
);

  // Data bit k sits at the k-th non-power-of-two codeword position (3, 5, 6, 7, 9, ... 38).
  function automatic logic [5:0] genChk(input logic [31:0] d);
    logic [5:0] g;
    logic [4:0] k;
    g = '0;
    k = '0;
    for (int p = 3; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        g = g ^ (6'(p) & {6{d[k]}});
        k = k + 5'd1;
      end
    end
    return g;
  endfunction

  function automatic logic [31:0] flipData(input logic [31:0] d, input logic [5:0] s);
    logic [31:0] r;
    logic [4:0]  k;
    r = d;
    k = '0;
    for (int p = 3; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (p == int'(s)) r = r ^ (32'd1 << k);
        k = k + 5'd1;
      end
    end
    return r;
  endfunction

  logic              s1Valid_q, s2Valid_q;
  logic              s1En_q;
  logic [ADDR_W-1:0] s1Addr_q, s2Addr_q;
  logic [31:0]       s1Data_q, s2Data_q, s2Data_d;
  logic [5:0]        s1Ecc_q, s2Ecc_q, s2Ecc_d;
  logic [5:0]        s1Syn_q, s1Syn_d, s2Syn_q;
  logic              s2Sec_q, s2Sec_d, s2Ued_q, s2Ued_d;
  logic [CNT_W-1:0]  secCnt_q, uedCnt_q;
  logic              failVld_q;
  logic [ADDR_W-1:0] failAddr_q;
  logic              advance, outAcc;

  assign advance  = !s2Valid_q || out_ready;
  assign in_ready = !s1Valid_q || advance;
  assign outAcc   = s2Valid_q && out_ready;

  // A zero syndrome in bypass lets stage 2 treat the word as clean with no extra gating.
  assign s1Syn_d = ecc_enable ? (in_ecc ^ genChk(in_data)) : 6'd0;

  always_comb begin
    s2Data_d = s1Data_q;
    s2Ecc_d  = s1Ecc_q;
    s2Sec_d  = 1'b0;
    s2Ued_d  = 1'b0;
    if (s1En_q && (s1Syn_q != 6'd0)) begin
      if ((s1Syn_q & (s1Syn_q - 6'd1)) == 6'd0) begin
        s2Ecc_d = s1Ecc_q ^ s1Syn_q;
        s2Sec_d = 1'b1;
      end else if (s1Syn_q <= 6'd38) begin
        s2Data_d = flipData(s1Data_q, s1Syn_q);
        s2Sec_d  = 1'b1;
      end else begin
        s2Ued_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1En_q    <= 1'b0;
      s1Addr_q  <= '0;
      s1Data_q  <= '0;
      s1Ecc_q   <= '0;
      s1Syn_q   <= '0;
      s2Valid_q <= 1'b0;
      s2Addr_q  <= '0;
      s2Data_q  <= '0;
      s2Ecc_q   <= '0;
      s2Syn_q   <= '0;
      s2Sec_q   <= 1'b0;
      s2Ued_q   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1Valid_q <= in_valid;
        if (in_valid) begin
          s1En_q   <= ecc_enable;
          s1Addr_q <= in_addr;
          s1Data_q <= in_data;
          s1Ecc_q  <= in_ecc;
          s1Syn_q  <= s1Syn_d;
        end
      end
      if (advance) begin
        s2Valid_q <= s1Valid_q;
        if (s1Valid_q) begin
          s2Addr_q <= s1Addr_q;
          s2Data_q <= s2Data_d;
          s2Ecc_q  <= s2Ecc_d;
          s2Syn_q  <= s1Syn_q;
          s2Sec_q  <= s2Sec_d;
          s2Ued_q  <= s2Ued_d;
        end
      end
    end
  end

  // Clear wins over the word accepted in the same cycle, so that word is never counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      secCnt_q   <= '0;
      uedCnt_q   <= '0;
      failVld_q  <= 1'b0;
      failAddr_q <= '0;
    end else if (clr_cnt) begin
      secCnt_q   <= '0;
      uedCnt_q   <= '0;
      failVld_q  <= 1'b0;
      failAddr_q <= '0;
    end else if (outAcc) begin
      if (s2Sec_q && (secCnt_q != '1)) secCnt_q <= secCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (s2Ued_q && (uedCnt_q != '1)) uedCnt_q <= uedCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (s2Ued_q && !failVld_q) begin
        failVld_q  <= 1'b1;
        failAddr_q <= s2Addr_q;
      end
    end
  end

  assign out_valid = s2Valid_q;
  assign out_addr  = s2Addr_q;
  assign out_data  = s2Data_q;
  assign out_ecc   = s2Ecc_q;
  assign out_syn   = s2Syn_q;
  assign out_sec   = s2Sec_q;
  assign out_ued   = s2Ued_q;
  assign sec_cnt   = secCnt_q;
  assign ued_cnt   = uedCnt_q;
  assign fail_vld  = failVld_q;
  assign fail_addr = failAddr_q;

endmodule
